// File: rtl/midi_msg_parser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | midi_msg_parser_if : byte-in / event-out bundle of the MIDI parser. Rev 1.0|
// +--------------------------------------------------------------------------+
interface midi_msg_parser_if;
  logic        byte_valid_i;
  logic [7:0]  midi_byte_i;
  logic [15:0] channel_mask_i;
  logic        note_valid_o;
  logic        note_on_o;
  logic [3:0]  note_channel_o;
  logic [6:0]  note_o;
  logic [6:0]  velocity_o;
  logic        cc_valid_o;
  logic [3:0]  cc_channel_o;
  logic [6:0]  cc_num_o;
  logic [6:0]  cc_value_o;
  logic        bend_valid_o;
  logic [3:0]  bend_channel_o;
  logic [13:0] bend_value_o;
  logic        error_o;

  modport master (
    output byte_valid_i, midi_byte_i, channel_mask_i,
    input  note_valid_o, note_on_o, note_channel_o, note_o, velocity_o,
    input  cc_valid_o, cc_channel_o, cc_num_o, cc_value_o,
    input  bend_valid_o, bend_channel_o, bend_value_o, error_o
  );

  modport slave (
    input  byte_valid_i, midi_byte_i, channel_mask_i,
    output note_valid_o, note_on_o, note_channel_o, note_o, velocity_o,
    output cc_valid_o, cc_channel_o, cc_num_o, cc_value_o,
    output bend_valid_o, bend_channel_o, bend_value_o, error_o
  );
endinterface
`default_nettype wire

// File: rtl/midi_msg_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | midi_msg_parser : MIDI byte stream to note / CC / pitch-bend events. Rev 1.0|
// +--------------------------------------------------------------------------+
module midi_msg_parser #(
  parameter bit          RUNNING_STATUS = 1'b1,
  parameter bit          VEL0_IS_OFF    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset,
  midi_msg_parser_if.slave   bus_if
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_D1, S_WAIT_D2, S_SYSEX} state_t;

  localparam int unsigned          c_CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit                   c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam state_t               c_DONE_STATE = RUNNING_STATUS ? S_WAIT_D1 : S_IDLE;

  // Status type is kept as status[6:4]: 0=8x note-off ... 6=Ex pitch bend
  localparam logic [2:0] c_T_NOFF = 3'd0, c_T_NON = 3'd1, c_T_CC = 3'd3,
                         c_T_PC   = 3'd4, c_T_CP  = 3'd5, c_T_BEND = 3'd6;

  state_t               state_q;
  logic [2:0]           type_q;
  logic [3:0]           chan_q;
  logic [6:0]           d1_q;
  logic [c_CNT_W-1:0]   cnt_q;
  logic                 note_valid_q, note_on_q, cc_valid_q, bend_valid_q, error_q;
  logic [3:0]           note_channel_q, cc_channel_q, bend_channel_q;
  logic [6:0]           note_q, velocity_q, cc_num_q, cc_value_q;
  logic [13:0]          bend_value_q;

  logic       w_byte_ok;
  logic [6:0] w_data;
  logic       w_ch_en;

  // Real-time bytes (F8-FF) are invisible to the parser
  assign w_byte_ok = bus_if.byte_valid_i && (bus_if.midi_byte_i[7:3] != 5'b11111);
  assign w_data    = bus_if.midi_byte_i[6:0];
  assign w_ch_en   = bus_if.channel_mask_i[chan_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      type_q         <= '0;
      chan_q         <= '0;
      d1_q           <= '0;
      cnt_q          <= '0;
      note_valid_q   <= 1'b0;
      note_on_q      <= 1'b0;
      note_channel_q <= '0;
      note_q         <= '0;
      velocity_q     <= '0;
      cc_valid_q     <= 1'b0;
      cc_channel_q   <= '0;
      cc_num_q       <= '0;
      cc_value_q     <= '0;
      bend_valid_q   <= 1'b0;
      bend_channel_q <= '0;
      bend_value_q   <= '0;
      error_q        <= 1'b0;
    end else begin
      note_valid_q <= 1'b0;
      cc_valid_q   <= 1'b0;
      bend_valid_q <= 1'b0;
      error_q      <= 1'b0;
      if (w_byte_ok) begin
        if (bus_if.midi_byte_i[7]) begin
          if (bus_if.midi_byte_i[7:4] != 4'hF) begin
            type_q  <= bus_if.midi_byte_i[6:4];
            chan_q  <= bus_if.midi_byte_i[3:0];
            state_q <= S_WAIT_D1;
          end else begin
            type_q  <= '0;
            chan_q  <= '0;
            state_q <= (bus_if.midi_byte_i == 8'hF0) ? S_SYSEX : S_IDLE;
          end
        end else begin
          case (state_q)
            S_IDLE:    error_q <= 1'b1;
            S_WAIT_D1: begin
              d1_q <= w_data;
              if (type_q == c_T_PC || type_q == c_T_CP) begin
                state_q <= c_DONE_STATE;
              end else begin
                state_q <= S_WAIT_D2;
                cnt_q   <= '0;
              end
            end
            S_WAIT_D2: begin
              state_q <= c_DONE_STATE;
              if (w_ch_en) begin
                if (type_q == c_T_NOFF || type_q == c_T_NON) begin
                  note_valid_q   <= 1'b1;
                  note_on_q      <= (type_q == c_T_NON) && ((|w_data) || !VEL0_IS_OFF);
                  note_channel_q <= chan_q;
                  note_q         <= d1_q;
                  velocity_q     <= w_data;
                end else if (type_q == c_T_CC) begin
                  cc_valid_q   <= 1'b1;
                  cc_channel_q <= chan_q;
                  cc_num_q     <= d1_q;
                  cc_value_q   <= w_data;
                end else if (type_q == c_T_BEND) begin
                  bend_valid_q   <= 1'b1;
                  bend_channel_q <= chan_q;
                  bend_value_q   <= {w_data, d1_q};
                end
              end
            end
            S_SYSEX: ;
            default: state_q <= S_IDLE;
          endcase
        end
      end else if (c_TIMEOUT_EN && !bus_if.byte_valid_i && state_q == S_WAIT_D2) begin
        // A real-time byte does not age the pending first data byte
        if (cnt_q == c_CNT_LAST) begin
          error_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WAIT_D1;
        end else begin
          cnt_q <= cnt_q + c_CNT_W'(1);
        end
      end
    end
  end

  assign bus_if.note_valid_o   = note_valid_q;
  assign bus_if.note_on_o      = note_on_q;
  assign bus_if.note_channel_o = note_channel_q;
  assign bus_if.note_o         = note_q;
  assign bus_if.velocity_o     = velocity_q;
  assign bus_if.cc_valid_o     = cc_valid_q;
  assign bus_if.cc_channel_o   = cc_channel_q;
  assign bus_if.cc_num_o       = cc_num_q;
  assign bus_if.cc_value_o     = cc_value_q;
  assign bus_if.bend_valid_o   = bend_valid_q;
  assign bus_if.bend_channel_o = bend_channel_q;
  assign bus_if.bend_value_o   = bend_value_q;
  assign bus_if.error_o        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_midi_msg_parser : directed vector bench for midi_msg_parser. Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_midi_msg_parser;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  midi_byte = 8'h00;
  logic [15:0] mask = 16'hFFFF;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  // a: defaults, b: no running status, c: timeout 8 with velocity-0 as note-on
  midi_msg_parser_if ia ();
  midi_msg_parser_if ib ();
  midi_msg_parser_if ic ();

  assign ia.byte_valid_i = byte_valid;  assign ia.midi_byte_i = midi_byte;  assign ia.channel_mask_i = mask;
  assign ib.byte_valid_i = byte_valid;  assign ib.midi_byte_i = midi_byte;  assign ib.channel_mask_i = mask;
  assign ic.byte_valid_i = byte_valid;  assign ic.midi_byte_i = midi_byte;  assign ic.channel_mask_i = mask;

  midi_msg_parser #(.RUNNING_STATUS(1'b1), .VEL0_IS_OFF(1'b1), .TIMEOUT_CYCLES(0))
    dut_a (.clock(clock), .reset(reset), .bus_if(ia));
  midi_msg_parser #(.RUNNING_STATUS(1'b0), .VEL0_IS_OFF(1'b1), .TIMEOUT_CYCLES(0))
    dut_b (.clock(clock), .reset(reset), .bus_if(ib));
  midi_msg_parser #(.RUNNING_STATUS(1'b1), .VEL0_IS_OFF(1'b0), .TIMEOUT_CYCLES(8))
    dut_c (.clock(clock), .reset(reset), .bus_if(ic));

  // kind: 0 none, 1 note, 2 cc, 3 bend, 4 error
  typedef struct {
    logic        v;
    logic [7:0]  b;
    logic [15:0] m;
    int          kind;
    logic        on;
    logic [3:0]  ch;
    logic [13:0] x;
    logic [6:0]  y;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] b, logic [15:0] m, int kind,
                              logic on, logic [3:0] ch, logic [13:0] x, logic [6:0] y);
    vec_t r;
    r.v = v; r.b = b; r.m = m; r.kind = kind; r.on = on; r.ch = ch; r.x = x; r.y = y;
    return r;
  endfunction

  function automatic vec_t nn(logic [7:0] b);
    return mk(1'b1, b, 16'hFFFF, 0, 1'b0, 4'h0, 14'h0, 7'h0);
  endfunction

  function automatic vec_t nt(logic [7:0] b, logic on, logic [3:0] ch, logic [6:0] n, logic [6:0] vel);
    return mk(1'b1, b, 16'hFFFF, 1, on, ch, {7'h0, n}, vel);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b);
    byte_valid = v;
    midi_byte  = b;
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_vec(input int i, input vec_t e);
    chk($sformatf("v%0d note_valid", i), ia.note_valid_o, e.kind == 1);
    chk($sformatf("v%0d cc_valid", i),   ia.cc_valid_o,   e.kind == 2);
    chk($sformatf("v%0d bend_valid", i), ia.bend_valid_o, e.kind == 3);
    chk($sformatf("v%0d error", i),      ia.error_o,      e.kind == 4);
    if (e.kind == 1) begin
      chk($sformatf("v%0d note_on", i),  ia.note_on_o,      e.on);
      chk($sformatf("v%0d note_ch", i),  ia.note_channel_o, e.ch);
      chk($sformatf("v%0d note", i),     ia.note_o,         e.x[6:0]);
      chk($sformatf("v%0d velocity", i), ia.velocity_o,     e.y);
    end
    if (e.kind == 2) begin
      chk($sformatf("v%0d cc_ch", i),    ia.cc_channel_o, e.ch);
      chk($sformatf("v%0d cc_num", i),   ia.cc_num_o,     e.x[6:0]);
      chk($sformatf("v%0d cc_value", i), ia.cc_value_o,   e.y);
    end
    if (e.kind == 3) begin
      chk($sformatf("v%0d bend_ch", i),  ia.bend_channel_o, e.ch);
      chk($sformatf("v%0d bend_val", i), ia.bend_value_o,   e.x);
    end
  endtask

  initial begin
    tbl.push_back(nn(8'h90)); tbl.push_back(nn(8'h3C));
    tbl.push_back(nt(8'h64, 1'b1, 4'h0, 7'h3C, 7'h64));
    tbl.push_back(nn(8'h93)); tbl.push_back(nn(8'h40));
    tbl.push_back(nt(8'h7F, 1'b1, 4'h3, 7'h40, 7'h7F));
    tbl.push_back(nn(8'h40));
    tbl.push_back(nt(8'h00, 1'b0, 4'h3, 7'h40, 7'h00));
    tbl.push_back(nn(8'hB1)); tbl.push_back(nn(8'h07)); tbl.push_back(nn(8'hF8));
    tbl.push_back(mk(1'b1, 8'h55, 16'hFFFF, 2, 1'b0, 4'h1, 14'h07, 7'h55));
    tbl.push_back(nn(8'hE2)); tbl.push_back(nn(8'h00));
    tbl.push_back(mk(1'b1, 8'h40, 16'hFFFF, 3, 1'b0, 4'h2, 14'h2000, 7'h0));
    tbl.push_back(mk(1'b1, 8'hE2, 16'hFFFB, 0, 1'b0, 4'h0, 14'h0, 7'h0));
    tbl.push_back(mk(1'b1, 8'h00, 16'hFFFB, 0, 1'b0, 4'h0, 14'h0, 7'h0));
    tbl.push_back(mk(1'b1, 8'h40, 16'hFFFB, 0, 1'b0, 4'h0, 14'h0, 7'h0));
    tbl.push_back(nn(8'hF0)); tbl.push_back(nn(8'h12)); tbl.push_back(nn(8'h34));
    tbl.push_back(nn(8'hF7));
    tbl.push_back(mk(1'b1, 8'h3C, 16'hFFFF, 4, 1'b0, 4'h0, 14'h0, 7'h0));
    tbl.push_back(nn(8'hC5)); tbl.push_back(nn(8'h10)); tbl.push_back(nn(8'h20));
    tbl.push_back(nn(8'h85)); tbl.push_back(nn(8'h30));
    tbl.push_back(nt(8'h45, 1'b0, 4'h5, 7'h30, 7'h45));
    tbl.push_back(nn(8'hA0)); tbl.push_back(nn(8'h10)); tbl.push_back(nn(8'h20));
    tbl.push_back(nn(8'h91)); tbl.push_back(nn(8'h3C)); tbl.push_back(nn(8'hF3));
    tbl.push_back(mk(1'b1, 8'h40, 16'hFFFF, 4, 1'b0, 4'h0, 14'h0, 7'h0));
    tbl.push_back(mk(1'b0, 8'h40, 16'hFFFF, 0, 1'b0, 4'h0, 14'h0, 7'h0));
    tbl.push_back(nn(8'h92)); tbl.push_back(nn(8'h11)); tbl.push_back(nn(8'h95));
    tbl.push_back(nn(8'h22));
    tbl.push_back(nt(8'h33, 1'b1, 4'h5, 7'h22, 7'h33));
    tbl.push_back(nn(8'hF0)); tbl.push_back(nn(8'h9A)); tbl.push_back(nn(8'h01));
    tbl.push_back(nt(8'h02, 1'b1, 4'hA, 7'h01, 7'h02));
    tbl.push_back(mk(1'b0, 8'h7F, 16'hFFFF, 0, 1'b0, 4'h0, 14'h0, 7'h0));
    tbl.push_back(nn(8'h03));
    tbl.push_back(nt(8'h04, 1'b1, 4'hA, 7'h03, 7'h04));

    @(posedge clock);
    #1;
    chk("reset note_valid", ia.note_valid_o, 1'b0);
    chk("reset cc_valid",   ia.cc_valid_o,   1'b0);
    chk("reset bend_valid", ia.bend_valid_o, 1'b0);
    chk("reset error",      ia.error_o,      1'b0);
    chk("reset bend_value", ia.bend_value_o, 14'h0);
    chk("reset note",       ia.note_o,       7'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      mask = tbl[i].m;
      cyc(tbl[i].v, tbl[i].b);
      check_vec(i, tbl[i]);
    end
    mask = 16'hFFFF;

    // Reset mid-message discards the pending status and d1
    cyc(1'b1, 8'h90); cyc(1'b1, 8'h3C);
    pulse_reset();
    chk("midreset note_valid", ia.note_valid_o, 1'b0);
    cyc(1'b1, 8'h64);
    chk("midreset orphan err", ia.error_o, 1'b1);
    chk("midreset no note",    ia.note_valid_o, 1'b0);

    // No running status: trailing data bytes are orphans
    pulse_reset();
    cyc(1'b1, 8'h93); cyc(1'b1, 8'h40); cyc(1'b1, 8'h7F);
    chk("nors note_valid", ib.note_valid_o, 1'b1);
    chk("nors note_on",    ib.note_on_o,    1'b1);
    chk("nors note_ch",    ib.note_channel_o, 4'h3);
    cyc(1'b1, 8'h40);
    chk("nors err1",   ib.error_o,      1'b1);
    chk("nors nonote", ib.note_valid_o, 1'b0);
    cyc(1'b1, 8'h00);
    chk("nors err2",   ib.error_o,      1'b1);

    // Timeout of 8 cycles between data bytes
    pulse_reset();
    cyc(1'b1, 8'h90); cyc(1'b1, 8'h3C);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 8'h00);
      chk($sformatf("to idle%0d err", k), ic.error_o, k == 8);
    end
    cyc(1'b1, 8'h3C); cyc(1'b1, 8'h64);
    chk("to note_valid", ic.note_valid_o, 1'b1);
    chk("to note",       ic.note_o,       7'h3C);
    chk("to velocity",   ic.velocity_o,   7'h64);
    cyc(1'b1, 8'h3C); cyc(1'b1, 8'h00);
    chk("vel0 note_valid", ic.note_valid_o, 1'b1);
    chk("vel0 note_on",    ic.note_on_o,    1'b1);
    chk("vel0 velocity",   ic.velocity_o,   7'h00);

    // Status byte on the timeout cycle wins
    cyc(1'b1, 8'h3C);
    for (int k = 1; k <= 7; k++) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h91);
    chk("to status wins", ic.error_o, 1'b0);
    // Real-time byte does not age the counter
    cyc(1'b1, 8'h3C);
    for (int k = 1; k <= 7; k++) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hF8);
    chk("to rt no err", ic.error_o, 1'b0);
    cyc(1'b0, 8'h00);
    chk("to rt late err", ic.error_o, 1'b1);
    cyc(1'b1, 8'h3C); cyc(1'b1, 8'h10);
    chk("to after note_valid", ic.note_valid_o, 1'b1);
    chk("to after note_ch",    ic.note_channel_o, 4'h1);
    chk("to after velocity",   ic.velocity_o,   7'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
